// File: rtl/scope_pkg.sv
// ============================================================================
// Module  : scope_pkg
// Brief   : Shared widths, defaults and state encoding for the scope register
//           assembler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package scope_pkg;

   localparam int BYTE_W               = 8;
   localparam int WORD_W               = 32;
   localparam int BYTES_PER_WORD       = 4;
   localparam int TIMEOUT_CYCLES_DEF   = 50000;

   typedef enum logic [0:0] {
      IDLE    = 1'b0,
      COLLECT = 1'b1
   } state_t;

endpackage : scope_pkg

`default_nettype wire

// File: rtl/reg_assembler_if.sv
// ============================================================================
// Module  : reg_assembler_if
// Brief   : Byte-stream input and word handshake bundle for reg_assembler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

interface reg_assembler_if
   import scope_pkg::*;
#(
   parameter int BYTES = BYTES_PER_WORD
);

   logic                      newByte;
   logic [BYTE_W-1:0]         byteIn;
   logic                      wordAck;
   logic                      clearOverrun;
   logic [BYTE_W*BYTES-1:0]   word;
   logic                      wordValid;
   logic                      overrun;
   logic [1:0]                byteCount;
   logic                      timeout;

   modport master (
      output newByte, byteIn, wordAck, clearOverrun,
      input  word, wordValid, overrun, byteCount, timeout
   );

   modport slave (
      input  newByte, byteIn, wordAck, clearOverrun,
      output word, wordValid, overrun, byteCount, timeout
   );

endinterface : reg_assembler_if

`default_nettype wire

// File: rtl/gap_timer.sv
// ============================================================================
// Module  : gap_timer
// Brief   : Idle-gap counter; expire_o is high on the cycle the count reaches
//           LIMIT-1 while enabled and not cleared.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module gap_timer #(
   parameter int LIMIT = 50000,
   parameter int W     = 16
) (
   input  wire  clk,
   input  wire  rst,
   input  wire  clr_i,
   input  wire  en_i,
   output logic expire_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   always_comb begin
      expire_o = en_i && !clr_i && (cnt_q == W'(LIMIT - 1));
   end

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i || expire_o) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule : gap_timer

`default_nettype wire

// File: rtl/reg_assembler.sv
// ============================================================================
// Module  : reg_assembler
// Brief   : Packs MSB-first byte strobes into a word with valid/ack handshake,
//           sticky overrun and optional stale-partial timeout
//           (REG_ASSEMBLER_TIMEOUT_EN).
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module reg_assembler
   import scope_pkg::*;
#(
   parameter int BYTES          = BYTES_PER_WORD,
   parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
   parameter int TMR_W          = 16
) (
   input  wire              clk,
   input  wire              rst,
   reg_assembler_if.slave   bus
);

   localparam int WW = BYTE_W * BYTES;

   if (BYTES != 4) begin : g_bytes_chk
      $error("reg_assembler: BYTES must be 4");
   end

   if ((64'd1 << TMR_W) <= 64'(TIMEOUT_CYCLES)) begin : g_tmr_chk
      $error("reg_assembler: TMR_W too narrow for TIMEOUT_CYCLES");
   end

   state_t          state_q, state_d;
   logic [1:0]      cnt_q, cnt_d;
   logic [WW-1:0]   shift_q, shift_d;
   logic [WW-1:0]   word_q, word_d;
   logic            valid_q, valid_d;
   logic            ovr_q, ovr_d;
   logic            tout_q, tout_d;
   logic            w_expire;

`ifdef REG_ASSEMBLER_TIMEOUT_EN
   gap_timer #(
      .LIMIT (TIMEOUT_CYCLES),
      .W     (TMR_W)
   ) u_gap_timer (
      .clk      (clk),
      .rst      (rst),
      .clr_i    (bus.newByte || (state_q == IDLE)),
      .en_i     (state_q == COLLECT),
      .expire_o (w_expire)
   );
`else
   assign w_expire = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= 2'd0;
         shift_q <= '0;
         word_q  <= '0;
         valid_q <= 1'b0;
         ovr_q   <= 1'b0;
         tout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         word_q  <= word_d;
         valid_q <= valid_d;
         ovr_q   <= ovr_d;
         tout_q  <= tout_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      word_d  = word_q;
      valid_d = valid_q;
      ovr_d   = ovr_q;
      tout_d  = w_expire;

      if (bus.wordAck) begin
         valid_d = 1'b0;
      end
      if (bus.clearOverrun) begin
         ovr_d = 1'b0;
      end

      if (bus.newByte) begin
         shift_d = {shift_q[WW-BYTE_W-1:0], bus.byteIn};
         case (state_q)
            IDLE: begin
               state_d = COLLECT;
               cnt_d   = 2'd1;
            end
            COLLECT: begin
               if (cnt_q == 2'(BYTES - 1)) begin
                  state_d = IDLE;
                  cnt_d   = 2'd0;
                  word_d  = shift_d;
                  valid_d = 1'b1;
                  // Newest word wins; overrun set overrides a same-cycle clear.
                  if (valid_q && !bus.wordAck) begin
                     ovr_d = 1'b1;
                  end
               end else begin
                  cnt_d = cnt_q + 2'd1;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = 2'd0;
            end
         endcase
      end else if (w_expire) begin
         state_d = IDLE;
         cnt_d   = 2'd0;
         shift_d = '0;
      end
   end

   always_comb begin
      bus.word      = word_q;
      bus.wordValid = valid_q;
      bus.overrun   = ovr_q;
      bus.byteCount = cnt_q;
      bus.timeout   = tout_q;
   end

endmodule : reg_assembler

`default_nettype wire

// File: tb/tb_reg_assembler.sv
// ============================================================================
// Module  : tb_reg_assembler
// Brief   : Directed self-checking bench for reg_assembler.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_reg_assembler;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   reg_assembler_if #(.BYTES(4)) bus ();

   reg_assembler #(
      .BYTES          (4),
      .TIMEOUT_CYCLES (10),
      .TMR_W          (16)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic check_eq(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic send(input logic [7:0] b, input logic ack, input logic clr);
      bus.newByte      = 1'b1;
      bus.byteIn       = b;
      bus.wordAck      = ack;
      bus.clearOverrun = clr;
      tick();
      bus.newByte      = 1'b0;
      bus.byteIn       = 8'h00;
      bus.wordAck      = 1'b0;
      bus.clearOverrun = 1'b0;
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send(w[8*i +: 8], 1'b0, 1'b0);
   endtask

   task automatic ack();
      bus.wordAck = 1'b1;
      tick();
      bus.wordAck = 1'b0;
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      bus.newByte      = 1'b0;
      bus.byteIn       = 8'h00;
      bus.wordAck      = 1'b0;
      bus.clearOverrun = 1'b0;
      rst = 1'b1;
      idle(2);
      rst = 1'b0;

      check_eq("rst_word",  bus.word,      32'h0);
      check_eq("rst_valid", 32'(bus.wordValid), 32'd0);
      check_eq("rst_ovr",   32'(bus.overrun),   32'd0);
      check_eq("rst_cnt",   32'(bus.byteCount), 32'd0);
      check_eq("rst_tout",  32'(bus.timeout),   32'd0);

      // Spaced bytes
      send(8'hDE, 1'b0, 1'b0);
      check_eq("gap_cnt1", 32'(bus.byteCount), 32'd1);
      idle(1);
      send(8'hAD, 1'b0, 1'b0);
      idle(2);
      send(8'hBE, 1'b0, 1'b0);
      check_eq("gap_cnt3", 32'(bus.byteCount), 32'd3);
      check_eq("gap_valid_pre", 32'(bus.wordValid), 32'd0);
      idle(1);
      send(8'hEF, 1'b0, 1'b0);
      check_eq("gap_valid", 32'(bus.wordValid), 32'd1);
      check_eq("gap_word",  bus.word, 32'hDEADBEEF);
      check_eq("gap_cnt0",  32'(bus.byteCount), 32'd0);
      ack();
      check_eq("ack_valid", 32'(bus.wordValid), 32'd0);
      check_eq("ack_word",  bus.word, 32'hDEADBEEF);
      ack();
      check_eq("ack_idle_valid", 32'(bus.wordValid), 32'd0);

      // Back-to-back strobes
      send(8'h01, 1'b0, 1'b0);
      send(8'h02, 1'b0, 1'b0);
      send(8'h03, 1'b0, 1'b0);
      check_eq("b2b_valid_pre", 32'(bus.wordValid), 32'd0);
      send(8'h04, 1'b0, 1'b0);
      check_eq("b2b_valid", 32'(bus.wordValid), 32'd1);
      check_eq("b2b_word",  bus.word, 32'h01020304);
      ack();

      // Overrun
      send_word(32'h11223344);
      check_eq("ovr_first", bus.word, 32'h11223344);
      send_word(32'h55667788);
      check_eq("ovr_word",  bus.word, 32'h55667788);
      check_eq("ovr_valid", 32'(bus.wordValid), 32'd1);
      check_eq("ovr_flag",  32'(bus.overrun),   32'd1);
      bus.clearOverrun = 1'b1;
      tick();
      bus.clearOverrun = 1'b0;
      check_eq("ovr_clr",       32'(bus.overrun),   32'd0);
      check_eq("ovr_clr_valid", 32'(bus.wordValid), 32'd1);

      // Overrun set beats same-cycle clear
      send(8'h99, 1'b0, 1'b0);
      send(8'hAA, 1'b0, 1'b0);
      send(8'hBB, 1'b0, 1'b0);
      send(8'hCC, 1'b0, 1'b1);
      check_eq("setclr_ovr",  32'(bus.overrun), 32'd1);
      check_eq("setclr_word", bus.word, 32'h99AABBCC);
      bus.clearOverrun = 1'b1;
      tick();
      bus.clearOverrun = 1'b0;

      // Completion concurrent with ack
      send(8'hC0, 1'b0, 1'b0);
      send(8'hC1, 1'b0, 1'b0);
      send(8'hC2, 1'b0, 1'b0);
      send(8'hC3, 1'b1, 1'b0);
      check_eq("cack_word",  bus.word, 32'hC0C1C2C3);
      check_eq("cack_valid", 32'(bus.wordValid), 32'd1);
      check_eq("cack_ovr",   32'(bus.overrun),   32'd0);

      // Mid-word reset with pending word and overrun
      send_word(32'h12345678);
      check_eq("pre_rst_ovr", 32'(bus.overrun), 32'd1);
      send(8'hF0, 1'b0, 1'b0);
      send(8'hF1, 1'b0, 1'b0);
      send(8'hF2, 1'b0, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check_eq("mrst_word",  bus.word, 32'h0);
      check_eq("mrst_valid", 32'(bus.wordValid), 32'd0);
      check_eq("mrst_ovr",   32'(bus.overrun),   32'd0);
      check_eq("mrst_cnt",   32'(bus.byteCount), 32'd0);
      send_word(32'h0A0B0C0D);
      check_eq("post_rst_word", bus.word, 32'h0A0B0C0D);
      check_eq("post_rst_ovr",  32'(bus.overrun), 32'd0);
      ack();

`ifdef REG_ASSEMBLER_TIMEOUT_EN
      send(8'hB0, 1'b0, 1'b0);
      send(8'hB1, 1'b0, 1'b0);
      idle(9);
      check_eq("to_cnt_9",  32'(bus.byteCount), 32'd2);
      check_eq("to_tout_9", 32'(bus.timeout),   32'd0);
      idle(1);
      check_eq("to_tout",   32'(bus.timeout),   32'd1);
      check_eq("to_cnt",    32'(bus.byteCount), 32'd0);
      idle(1);
      check_eq("to_pulse",  32'(bus.timeout),   32'd0);
      check_eq("to_valid",  32'(bus.wordValid), 32'd0);
      send_word(32'hA0A1A2A3);
      check_eq("to_word",   bus.word, 32'hA0A1A2A3);
      ack();

      // Byte on gap cycle 9, then on the expiry cycle itself
      send(8'h10, 1'b0, 1'b0);
      idle(8);
      send(8'h20, 1'b0, 1'b0);
      check_eq("g9_tout", 32'(bus.timeout),   32'd0);
      check_eq("g9_cnt",  32'(bus.byteCount), 32'd2);
      idle(9);
      send(8'h30, 1'b0, 1'b0);
      check_eq("g10_tout", 32'(bus.timeout),   32'd0);
      check_eq("g10_cnt",  32'(bus.byteCount), 32'd3);
      idle(9);
      send(8'h40, 1'b0, 1'b0);
      check_eq("g10_word",  bus.word, 32'h10203040);
      check_eq("g10_valid", 32'(bus.wordValid), 32'd1);
      ack();
`else
      send(8'hB0, 1'b0, 1'b0);
      send(8'hB1, 1'b0, 1'b0);
      idle(20);
      check_eq("nto_cnt",  32'(bus.byteCount), 32'd2);
      check_eq("nto_tout", 32'(bus.timeout),   32'd0);
      send(8'hB2, 1'b0, 1'b0);
      send(8'hB3, 1'b0, 1'b0);
      check_eq("nto_word", bus.word, 32'hB0B1B2B3);
      ack();
`endif

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end

endmodule : tb_reg_assembler

`default_nettype wire

// File: doc/reg_assembler.md
Name: reg_assembler

Overview:
- Receive-side counterpart of the scope's register splitter.
- Collects a stream of byte strobes, for example from the UART receiver, MSB first, into one 32-bit word.
- Presents each completed word to the control logic with a valid/ack handshake.
- Flags overruns and, optionally, discards stale partial words after an inter-byte gap timeout.

Parameters:
- BYTES, 4, number of bytes per assembled word; word width is 8*BYTES.
- TIMEOUT_CYCLES, 50000, idle clk cycles allowed between bytes of one word (used only with the optional feature).
- TMR_W, 16, width of the gap timer counter; must satisfy 2^TMR_W > TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- newByte  in  1  one-cycle strobe; byteIn valid this cycle
- byteIn  in  8  received byte
- wordAck  in  1  consumer accepts word; meaningful only while wordValid=1
- clearOverrun  in  1  clears the sticky overrun flag
- word  out  8*BYTES  assembled word; first received byte in the MSBs
- wordValid  out  1  word holds an unconsumed value
- overrun  out  1  sticky: a word was overwritten before being acked
- byteCount  out  2  bytes collected toward the current word, 0..BYTES-1
- timeout  out  1  one-cycle pulse when a partial word is discarded

Behaviour:
- Reset, synchronous and active-high, sampled on rising clk: word=0, wordValid=0, overrun=0, byteCount=0, timeout=0, shift register=0, gap timer=0. Reset asserted mid-word discards the partial word and any pending valid word.
- States:
  - IDLE: byteCount=0.
  - COLLECT: byteCount 1..BYTES-1.
  - newByte in IDLE moves to COLLECT with byteCount=1.
  - newByte in COLLECT increments byteCount.
  - newByte at byteCount=BYTES-1 completes the word and returns to IDLE.
- Shift register: each newByte shifts it left 8 and loads byteIn into the low byte.
- Completion, on the cycle of the final newByte:
  - word <= {shift[8*(BYTES-1)-1:0], byteIn}.
  - wordValid=1 from the next cycle (latency 1 clk from final strobe to valid).
  - word stays stable while wordValid=1 unless overwritten by an overrun.
- Handshake:
  - wordAck with wordValid=1 clears wordValid on that edge.
  - wordAck with wordValid=0 is ignored.
  - Completion and wordAck in the same cycle: the old word is consumed, the new word loads, and wordValid stays 1; no overrun.
- Overrun:
  - Completion while wordValid=1 and wordAck=0: the new word overwrites word (newest wins), wordValid stays 1, overrun sets.
  - overrun stays set until clearOverrun or rst.
  - Set and clear in the same cycle: set wins.
- byteIn is ignored when newByte=0.
- BYTES=4 is the only supported value for byteCount width 2; other values are out of scope for this revision.

Optional Feature:
- Macro REG_ASSEMBLER_TIMEOUT_EN.
- Defined:
  - Gap timer clears on every newByte and counts each cycle while in COLLECT.
  - When it reaches TIMEOUT_CYCLES-1 with no newByte that cycle: shift register and byteCount clear to IDLE and timeout pulses high for 1 cycle.
  - wordValid, word and overrun are unaffected by a timeout.
  - newByte in the same cycle the timer would expire: no timeout; the byte is accepted normally.
  - The timer is held at 0 in IDLE.
- Undefined: no timer logic; timeout is tied to 0; a partial word waits indefinitely.

Decomposition:
- Shared package scope_pkg: BYTE_W=8, WORD_W=32, BYTES_PER_WORD=4, a state enum {IDLE, COLLECT}, and a default TIMEOUT_CYCLES constant.
- One natural sub-module: gap_timer (TMR_W counter with clear, enable and expire pulse). It is instantiated only under REG_ASSEMBLER_TIMEOUT_EN.

Test Plan:
- rst, then newByte with 0xDE,0xAD,0xBE,0xEF on non-consecutive cycles -> one cycle after 0xEF: wordValid=1, word=0xDEADBEEF, byteCount=0; wordAck -> wordValid=0 next cycle.
- Four back-to-back strobes 0x01..0x04 with no gaps -> word=0x01020304, wordValid=1 exactly 1 cycle after the 4th strobe.
- Word 0x11223344 pending un-acked, then a second word 0x55667788 completes -> word=0x55667788, wordValid=1, overrun=1; clearOverrun -> overrun=0.
- Pending word; final byte of the next word arrives in the same cycle as wordAck -> word=the new value, wordValid stays 1, overrun=0.
- With REG_ASSEMBLER_TIMEOUT_EN and TIMEOUT_CYCLES=10:
  - Send 2 bytes, idle 10 cycles -> timeout pulses 1 cycle and byteCount=0.
  - Then 0xA0,0xA1,0xA2,0xA3 -> word=0xA0A1A2A3.
  - A byte at exactly cycle 9 of a gap -> no timeout.
- rst asserted after 3 bytes and with a pending word -> all outputs 0 next cycle; next 4 bytes assemble correctly.
